// File: rtl/arb_pkg.sv
// Shared arbitration mode encodings for the arbitrated output mux.
package arb_pkg;
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter with one-hot and encoded grant.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  logic [2*NCH-1:0] w_dbl;
  logic [SELW-1:0]  w_start;
  logic             w_found;

  // Scanning the doubled request vector from w_start handles wrap-around
  // without a separate second pass; bits below w_start are masked off.
  always_comb begin
    w_start = (arb_mode_e'(mode) == ARB_FIXED) ? '0 : ptr;
    w_dbl   = {req, req};
    w_found = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    for (int unsigned i = 0; i < 2 * NCH; i++) begin
      if (!w_found && w_dbl[i] && (i >= 32'(w_start))) begin
        w_found = 1'b1;
        gnt_idx = SELW'(i % NCH);
      end
    end
    if (w_found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_mux_nx.sv
// N-channel arbitrated mux with a one-beat registered output stage and back-pressure.
module arb_mux_nx
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 mode,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  r_ptr;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_sel;

  logic             w_load;
  logic [NCH-1:0]   w_gnt;
  logic [SELW-1:0]  w_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .mode    (mode),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  assign w_load   = !r_valid || out_ready;
  assign in_ready = w_gnt & {NCH{w_load}};
  assign w_xfer   = |(in_valid & in_ready);

  always_comb begin
    w_mux = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_mux = w_mux | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_mux;
        r_sel   <= w_idx;
        if (arb_mode_e'(mode) == ARB_RR) begin
          r_ptr <= (w_idx == SELW'(NCH - 1)) ? '0 : w_idx + SELW'(1);
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_arb_mux_nx.sv
// Randomised and directed bench for arb_mux_nx (NCH=4/WIDTH=32 and NCH=3/WIDTH=8).
module tb_arb_mux_nx;

  logic         clk  = 1'b0;
  logic         clrn = 1'b0;
  logic         mode = 1'b0;

  logic [3:0]   iv4;
  logic [127:0] id4;
  logic [3:0]   ir4;
  logic         ov4;
  logic [31:0]  od4;
  logic [1:0]   os4;
  logic         ordy4;

  logic [2:0]   iv3;
  logic [23:0]  id3;
  logic [2:0]   ir3;
  logic         ov3;
  logic [7:0]   od3;
  logic [1:0]   os3;
  logic         ordy3;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit          mv4, mv3;
  logic [31:0] md4;
  logic [7:0]  md3;
  int          ms4, ms3, mp4, mp3;

  always #5 clk = ~clk;

  arb_mux_nx #(.WIDTH(32), .NCH(4)) u_dut4 (
    .clk(clk), .clrn(clrn), .mode(mode),
    .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
  );

  arb_mux_nx #(.WIDTH(8), .NCH(3)) u_dut3 (
    .clk(clk), .clrn(clrn), .mode(mode),
    .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // First requesting channel at or after the start index, modulo n.
  function automatic int pick(input int n, input logic [3:0] v, input int p, input bit fixed);
    int s;
    s = fixed ? 0 : p;
    for (int k = 0; k < n; k++) begin
      if (v[(s + k) % n]) return (s + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mv4 = 0; md4 = '0; ms4 = 0; mp4 = 0;
    mv3 = 0; md3 = '0; ms3 = 0; mp3 = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    int g4, g3;
    logic [3:0] er4;
    logic [2:0] er3;
    bit ld4, ld3;
    #1;
    ld4 = !mv4 || ordy4;
    g4  = pick(4, iv4, mp4, mode);
    er4 = (ld4 && g4 >= 0) ? 4'(1 << g4) : 4'b0;
    chk("in_ready4", 64'(ir4), 64'(er4));
    ld3 = !mv3 || ordy3;
    g3  = pick(3, {1'b0, iv3}, mp3, mode);
    er3 = (ld3 && g3 >= 0) ? 3'(1 << g3) : 3'b0;
    chk("in_ready3", 64'(ir3), 64'(er3));

    if (er4 != 0) begin
      mv4 = 1; md4 = id4[g4*32 +: 32]; ms4 = g4;
      if (!mode) mp4 = (g4 + 1) % 4;
    end else if (mv4 && ordy4) mv4 = 0;
    if (er3 != 0) begin
      mv3 = 1; md3 = id3[g3*8 +: 8]; ms3 = g3;
      if (!mode) mp3 = (g3 + 1) % 3;
    end else if (mv3 && ordy3) mv3 = 0;

    @(posedge clk);
    #1;
    chk("out_valid4", 64'(ov4), 64'(mv4));
    chk("out_data4",  64'(od4), 64'(md4));
    chk("out_sel4",   64'(os4), 64'(ms4));
    chk("out_valid3", 64'(ov3), 64'(mv3));
    chk("out_data3",  64'(od3), 64'(md3));
    chk("out_sel3",   64'(os3), 64'(ms3));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    bit got3;
    iv4 = '0; id4 = '0; ordy4 = 1'b1;
    iv3 = '0; id3 = '0; ordy3 = 1'b1;
    model_reset();
    #2;
    chk("rst_valid4", 64'(ov4), 64'd0);
    chk("rst_data4",  64'(od4), 64'd0);
    chk("rst_sel4",   64'(os4), 64'd0);
    #10 clrn = 1'b1;
    @(negedge clk);

    // Round-robin full load on both instances.
    mode = 1'b0;
    iv4 = 4'hF;
    id4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    iv3 = 3'b111;
    id3 = {8'h33, 8'h22, 8'h11};
    for (int j = 0; j < 5; j++) begin
      step();
      chk("rr_seq4",  64'(os4), 64'(j % 4));
      chk("rr_data4", 64'(od4), 64'(32'hA0 + (j % 4)));
      chk("rr_seq3",  64'(os3), 64'(j % 3));
    end

    // Fixed-priority starvation, then resume round-robin.
    mode = 1'b1;
    iv4  = 4'b1010;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("fixed_no3", 64'(ir4[3]), 64'd0);
      chk("fixed_sel", 64'(os4), 64'd1);
    end
    mode = 1'b0;
    got3 = 0;
    for (int j = 0; j < 2; j++) begin
      step();
      if (os4 == 2'd3) got3 = 1;
    end
    chk("rr_resume3", 64'(got3), 64'd1);

    // Back-pressure: hold stable, then drain and reload without a bubble.
    iv4 = 4'hF;
    step();
    held  = od4;
    ordy4 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("bp_hold",  64'(od4), 64'(held));
      chk("bp_nordy", 64'(ir4), 64'd0);
    end
    ordy4 = 1'b1;
    step();
    chk("bp_nobubble", 64'(ov4), 64'd1);

    // Sparse requests on channel 2 only.
    for (int j = 0; j < 8; j++) begin
      iv4 = (j % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
    end
    chk("sparse_ptr", 64'(mp4), 64'd3);

    // Randomised traffic.
    for (int j = 0; j < 400; j++) begin
      iv4   = 4'($urandom);
      id4   = {$urandom, $urandom, $urandom, $urandom};
      iv3   = 3'($urandom);
      id3   = 24'($urandom);
      mode  = ($urandom_range(0, 7) == 0);
      ordy4 = ($urandom_range(0, 3) != 0);
      ordy3 = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset while a beat is held.
    iv4 = 4'hF; id4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    iv3 = 3'b111; ordy4 = 1'b1; ordy3 = 1'b1; mode = 1'b0;
    step();
    chk("pre_rst_valid", 64'(ov4), 64'd1);
    clrn = 1'b0;
    #1;
    chk("async_valid4", 64'(ov4), 64'd0);
    chk("async_data4",  64'(od4), 64'd0);
    chk("async_sel4",   64'(os4), 64'd0);
    chk("async_valid3", 64'(ov3), 64'd0);
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
    step();
    chk("post_rst_sel4", 64'(os4), 64'd0);
    step();
    chk("post_rst_next", 64'(os4), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
